adc_responder: RTL

Synthesizable behavioural model of an ADC0809-class 8-channel, 8-bit converter: the responder side of the start/ale/oe/address/eoc/data handshake that the ADC controller drives. It takes eight parallel channel samples, latches the channel address on ALE, runs a timed conversion after START, drops and raises EOC, and drives the held result while OE is asserted. It replaces the physical ADC in FPGA-level loopback and in the controller's verification bench.

---
 rtl/adc_responder_if.sv | 56 +++++
 rtl/adc_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adc_responder_if.sv
// -----------------------------------------------------------------------------
// adc_responder_if
//
// Handshake bundle between an ADC0809-style controller and the converter
// (or its behavioural stand-in, adc_responder).
//
// Signals:
//   start        controller -> ADC  conversion start
//   ale          controller -> ADC  address latch enable
//   oe           controller -> ADC  output enable
//   address[2:0] controller -> ADC  channel select, latched while ale is high
//   ch_data[63:0] source    -> ADC  eight 8-bit analog samples, channel k at [8k+7:8k]
//   eoc          ADC -> controller  end of conversion, low while converting
//   adc_data[7:0] ADC -> controller result while oe is enabled, else 0
//   adc_data_en  ADC -> controller  registered oe, pad drive enable
//   busy         ADC -> controller  converter not idle
//
// Modports:
//   master  the controller side (drives start/ale/oe/address and the samples)
//   slave   the converter side
// -----------------------------------------------------------------------------
interface adc_responder_if;
    logic        start;
    logic        ale;
    logic        oe;
    logic [2:0]  address;
    logic [63:0] ch_data;
    logic        eoc;
    logic [7:0]  adc_data;
    logic        adc_data_en;
    logic        busy;

    modport master (
        output start,
        output ale,
        output oe,
        output address,
        output ch_data,
        input  eoc,
        input  adc_data,
        input  adc_data_en,
        input  busy
    );

    modport slave (
        input  start,
        input  ale,
        input  oe,
        input  address,
        input  ch_data,
        output eoc,
        output adc_data,
        output adc_data_en,
        output busy
    );
endinterface

// File: rtl/adc_responder.sv
// -----------------------------------------------------------------------------
// adc_responder
//
// Behavioural, synthesizable model of an ADC0809-class 8-channel, 8-bit
// converter. It answers the start/ale/oe/address handshake of an ADC
// controller: the channel address is latched on ale, a start pulse triggers a
// sample-and-hold of the selected channel on its falling edge, eoc drops for a
// fixed conversion time and then rises with the result available through oe.
//
// Parameters:
//   EOC_DELAY    cycles from the start falling edge to eoc going low (1..15)
//   CONV_CYCLES  cycles eoc stays low during a conversion (1..255)
//
// Ports:
//   clock  sole clock, all inputs sampled on its rising edge
//   reset  asynchronous, active-low reset
//   bus    adc_responder_if.slave handshake bundle
//            in : start, ale, oe, address[2:0], ch_data[63:0]
//            out: eoc, adc_data[7:0], adc_data_en, busy
// -----------------------------------------------------------------------------
module adc_responder #(
    parameter int EOC_DELAY   = 2,
    parameter int CONV_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    adc_responder_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAR_RST = 2'd1,
        DELAY   = 2'd2,
        CONVERT = 2'd3
    } state_t;

    // Counter reload values; the counter expires one cycle after reaching 0,
    // so loading N-1 gives exactly N cycles in the state.
    localparam logic [7:0] DELAY_LOAD = 8'(EOC_DELAY - 1);
    localparam logic [7:0] CONV_LOAD  = 8'(CONV_CYCLES - 1);

    state_t      state_q,       state_d;
    logic [7:0]  cnt_q,         cnt_d;
    logic        start_q,       start_d;
    logic        ale_q,         ale_d;
    logic [2:0]  chan_q,        chan_d;
    logic [7:0]  hold_q,        hold_d;
    logic [7:0]  result_q,      result_d;
    logic        eoc_q,         eoc_d;
    logic [7:0]  adc_data_q,    adc_data_d;
    logic        adc_data_en_q, adc_data_en_d;

    logic        start_rise;
    logic        start_fall;
    logic [7:0]  sel_sample;

    assign start_rise = bus.start & ~start_q;
    assign start_fall = ~bus.start & start_q;

    // The latched channel (not the live address) selects the sample, so an
    // address presented together with ale on the start edge is already in
    // chan_q by the time the falling edge arrives.
    assign sel_sample = bus.ch_data[{chan_q, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        result_d      = result_q;
        eoc_d         = eoc_q;
        start_d       = bus.start;
        ale_d         = bus.ale;
        chan_d        = bus.ale ? bus.address : chan_q;

        // Output path is independent of the conversion FSM: oe always shows
        // the last completed result (0 before the first one).
        adc_data_d    = bus.oe ? result_q : 8'h00;
        adc_data_en_d = bus.oe;

        case (state_q)
            IDLE: begin
                eoc_d = 1'b1;
                if (start_rise) begin
                    state_d = SAR_RST;
                end
            end

            SAR_RST: begin
                eoc_d = 1'b1;
                if (start_fall) begin
                    // Sample-and-hold: later ch_data / chan changes are ignored.
                    hold_d  = sel_sample;
                    cnt_d   = DELAY_LOAD;
                    state_d = DELAY;
                end
            end

            DELAY: begin
                if (start_rise) begin
                    eoc_d   = 1'b1;
                    state_d = SAR_RST;
                end else if (cnt_q == 8'd0) begin
                    cnt_d   = CONV_LOAD;
                    eoc_d   = 1'b0;
                    state_d = CONVERT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            CONVERT: begin
                if (start_rise) begin
                    // Abort: the previous result stays in result_q.
                    eoc_d   = 1'b1;
                    state_d = SAR_RST;
                end else if (cnt_q == 8'd0) begin
                    result_d = hold_q;
                    eoc_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                eoc_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            start_q       <= 1'b0;
            ale_q         <= 1'b0;
            chan_q        <= 3'd0;
            hold_q        <= 8'h00;
            result_q      <= 8'h00;
            eoc_q         <= 1'b1;
            adc_data_q    <= 8'h00;
            adc_data_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            ale_q         <= ale_d;
            chan_q        <= chan_d;
            hold_q        <= hold_d;
            result_q      <= result_d;
            eoc_q         <= eoc_d;
            adc_data_q    <= adc_data_d;
            adc_data_en_q <= adc_data_en_d;
        end
    end

    assign bus.eoc         = eoc_q;
    assign bus.adc_data    = adc_data_q;
    assign bus.adc_data_en = adc_data_en_q;
    assign bus.busy        = (state_q != IDLE);

    // ale_q is the registered previous ale; it is kept for symmetry with the
    // start edge detector and for external probing of the latch timing.
    logic ale_unused;
    assign ale_unused = ale_q;

endmodule
